// File: rtl/sd_spi_engine_pkg.sv
// Shared SPI engine types: command and FSM state encodings, default dividers.
package sdspi_types;

  localparam int SDSPI_SLOW_DIV = 125;
  localparam int SDSPI_FAST_DIV = 2;

  typedef enum logic [2:0] {
    spiopNOP  = 3'd0,
    spiopCSL  = 3'd1,
    spiopCSH  = 3'd2,
    spiopFAST = 3'd3,
    spiopSLOW = 3'd4,
    spiopTR   = 3'd5
  } spiOP_t;

  typedef enum logic [2:0] {
    sdspiIDLE = 3'd0,
    sdspiLOW  = 3'd1,
    sdspiHIGH = 3'd2,
    sdspiDONE = 3'd3,
    sdspiACK  = 3'd4
  } sdspiSTATE_t;

endpackage

// File: rtl/sd_spi_engine_div.sv
// Loadable half-period down-counter: load sets div-1, tick while count is zero.
module sd_spi_div #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clear,
  input  logic         load,
  input  logic [W-1:0] div,
  output logic         tick
);

  logic [W-1:0] cnt;

  // Count down toward zero; a load restarts the half-period
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)              cnt <= '0;
    else if (clear)          cnt <= '0;
    else if (load)           cnt <= div - W'(1);
    else if (cnt != '0)      cnt <= cnt - W'(1);
  end

  assign tick = (cnt == '0);

endmodule

// File: rtl/sd_spi_engine.sv
// Byte-level SPI mode-0 master (MSB first) with CS and clock-speed commands.
module sd_spi_engine
  import sdspi_types::*;
#(
  parameter int SLOW_DIV = SDSPI_SLOW_DIV,
  parameter int FAST_DIV = SDSPI_FAST_DIV
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       clear,
  input  spiOP_t     spiOP,
  input  logic [0:7] spiTXD,
  output logic [0:7] spiRXD,
  output logic       spiDONE,
  output logic       spiBUSY,
  input  logic       sdMISO,
  output logic       sdMOSI,
  output logic       sdSCLK,
  output logic       sdCS
);

  localparam int DW = $clog2(SLOW_DIV + 1);
  localparam logic [DW-1:0] SLOW_V = DW'(SLOW_DIV);
  localparam logic [DW-1:0] FAST_V = DW'(FAST_DIV);

  sdspiSTATE_t   state_q, state_d;
  logic          fast_q;
  logic [DW-1:0] div_lat, div_val;
  logic          div_load, tick;
  logic [0:6]    tx;        // remaining TX bits after the one on MOSI
  logic [0:7]    rx;
  logic [2:0]    bitcnt;
  logic          sclk_q, mosi_q, cs_q, done_q, busy_q;
  logic [0:7]    rxd_q;
  logic          accept;

  assign accept  = (state_q == sdspiIDLE) && (spiOP != spiopNOP);
  // At accept the live mode is used; afterwards the latched divider keeps the byte at one speed
  assign div_val = (state_q == sdspiIDLE) ? (fast_q ? FAST_V : SLOW_V) : div_lat;

  sd_spi_div #(.W(DW)) u_div (
    .clk   (clk),
    .reset (reset),
    .clear (clear),
    .load  (div_load),
    .div   (div_val),
    .tick  (tick)
  );

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)     state_q <= sdspiIDLE;
    else if (clear) state_q <= sdspiIDLE;
    else            state_q <= state_d;
  end

  // Next state and divider reload strobe
  always_comb begin
    state_d  = state_q;
    div_load = 1'b0;
    unique case (state_q)
      sdspiIDLE: if (accept) begin
        if (spiOP == spiopTR) begin
          state_d  = sdspiLOW;
          div_load = 1'b1;
        end else begin
          state_d  = sdspiDONE;
        end
      end
      sdspiLOW: if (tick) begin
        state_d  = sdspiHIGH;
        div_load = 1'b1;
      end
      sdspiHIGH: if (tick) begin
        div_load = 1'b1;
        state_d  = (bitcnt == 3'd7) ? sdspiDONE : sdspiLOW;
      end
      sdspiDONE: state_d = sdspiACK;
      sdspiACK:  if (spiOP == spiopNOP) state_d = sdspiIDLE;
      default:   state_d = sdspiIDLE;
    endcase
  end

  // Pin drivers, shift registers and command side effects
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cs_q <= 1'b1; sclk_q <= 1'b0; mosi_q <= 1'b1; fast_q <= 1'b0;
      rxd_q <= '0; tx <= '1; rx <= '0; bitcnt <= '0; div_lat <= '0;
    end else if (clear) begin
      cs_q <= 1'b1; sclk_q <= 1'b0; mosi_q <= 1'b1; fast_q <= 1'b0;
      rxd_q <= '0; tx <= '1; rx <= '0; bitcnt <= '0; div_lat <= '0;
    end else begin
      unique case (state_q)
        sdspiIDLE: if (accept) begin
          unique case (spiOP)
            spiopCSL:  cs_q   <= 1'b0;
            spiopCSH:  cs_q   <= 1'b1;
            spiopFAST: fast_q <= 1'b1;
            spiopSLOW: fast_q <= 1'b0;
            spiopTR: begin
              tx      <= spiTXD[1:7];
              mosi_q  <= spiTXD[0];
              bitcnt  <= '0;
              div_lat <= div_val;
            end
            default: ;
          endcase
        end
        sdspiLOW: if (tick) begin
          sclk_q <= 1'b1;
          rx     <= {rx[1:7], sdMISO};
        end
        sdspiHIGH: if (tick) begin
          sclk_q <= 1'b0;
          bitcnt <= bitcnt + 3'd1;
          if (bitcnt == 3'd7) begin
            mosi_q <= 1'b1;
            rxd_q  <= rx;
          end else begin
            mosi_q <= tx[0];
            tx     <= {tx[1:6], 1'b1};
          end
        end
        default: ;
      endcase
    end
  end

  // Handshake flags trail the FSM by one cycle
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      done_q <= 1'b0; busy_q <= 1'b0;
    end else if (clear) begin
      done_q <= 1'b0; busy_q <= 1'b0;
    end else begin
      done_q <= (state_q == sdspiDONE);
      busy_q <= (state_q != sdspiIDLE);
    end
  end

  assign sdCS    = cs_q;
  assign sdSCLK  = sclk_q;
  assign sdMOSI  = mosi_q;
  assign spiRXD  = rxd_q;
  assign spiDONE = done_q;
  assign spiBUSY = busy_q;

endmodule

// File: tb/tb_sd_spi_engine.sv
// Directed bench for sd_spi_engine with a shift-out card model on MISO.
module tb_sd_spi_engine;
  import sdspi_types::*;

  logic       clk = 1'b0;
  logic       reset, clear;
  spiOP_t     spiOP;
  logic [0:7] spiTXD, spiRXD;
  logic       spiDONE, spiBUSY, sdMISO, sdMOSI, sdSCLK, sdCS;

  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  sd_spi_engine #(.SLOW_DIV(125), .FAST_DIV(2)) dut (
    .clk(clk), .reset(reset), .clear(clear), .spiOP(spiOP), .spiTXD(spiTXD),
    .spiRXD(spiRXD), .spiDONE(spiDONE), .spiBUSY(spiBUSY), .sdMISO(sdMISO),
    .sdMOSI(sdMOSI), .sdSCLK(sdSCLK), .sdCS(sdCS)
  );

  // Card model: MSB first, next bit presented on each SCLK falling edge
  logic [0:7] card_byte = 8'h00;
  logic       card_rst  = 1'b0;
  int         card_idx  = 0;
  always @(negedge sdSCLK or posedge card_rst)
    if (card_rst) card_idx = 0; else card_idx = card_idx + 1;
  assign sdMISO = card_byte[card_idx[2:0]];

  // Capture MOSI and time of every SCLK rising edge
  logic [0:7] mosi_cap = 8'h00;
  int         rise_cnt = 0;
  time        rise_t [16];
  always @(posedge sdSCLK) begin
    mosi_cap = {mosi_cap[1:7], sdMOSI};
    rise_t[rise_cnt % 16] = $time;
    rise_cnt++;
  end

  int done_cnt = 0, mosi0_cnt = 0;
  always @(posedge clk) begin
    if (spiDONE) done_cnt++;
    if (spiBUSY && !sdMOSI) mosi0_cnt++;
  end

  task automatic step(); @(posedge clk); #1; endtask

  task automatic issue(input spiOP_t op, input logic [0:7] d);
    spiOP = op; spiTXD = d; step();
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (!spiDONE && n < 5000) begin step(); n++; end
  endtask

  task automatic cmd(input spiOP_t op);
    int n;
    issue(op, 8'h00); wait_done(n); spiOP = spiopNOP; step(); step();
  endtask

  task automatic card_load(input logic [0:7] b);
    card_byte = b; card_rst = 1'b1; #1; card_rst = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b0; clear = 1'b0; spiOP = spiopNOP; spiTXD = 8'h00;
    step(); step(); reset = 1'b1; step();
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (sdCS !== 1'b1)     begin errors++; $display("FAIL rst_cs: got %b want 1", sdCS); end
    checks++; if (sdSCLK !== 1'b0)   begin errors++; $display("FAIL rst_sclk: got %b want 0", sdSCLK); end
    checks++; if (sdMOSI !== 1'b1)   begin errors++; $display("FAIL rst_mosi: got %b want 1", sdMOSI); end
    checks++; if (spiBUSY !== 1'b0)  begin errors++; $display("FAIL rst_busy: got %b want 0", spiBUSY); end
    checks++; if (spiDONE !== 1'b0)  begin errors++; $display("FAIL rst_done: got %b want 0", spiDONE); end
    checks++; if (spiRXD !== 8'h00)  begin errors++; $display("FAIL rst_rxd: got %h want 00", spiRXD); end
  endtask

  task automatic test_cs();
    int n, base;
    base = done_cnt;
    issue(spiopCSL, 8'h00);
    checks++; if (sdCS !== 1'b0) begin errors++; $display("FAIL csl_cs: got %b want 0", sdCS); end
    wait_done(n);
    checks++; if (n != 1) begin errors++; $display("FAIL csl_latency: got %0d want 1", n); end
    repeat (6) step();
    checks++; if (done_cnt - base != 1) begin errors++; $display("FAIL csl_held_done: got %0d want 1", done_cnt - base); end
    checks++; if (spiBUSY !== 1'b1) begin errors++; $display("FAIL csl_held_busy: got %b want 1", spiBUSY); end
    spiOP = spiopNOP; step(); step();
    checks++; if (spiBUSY !== 1'b0) begin errors++; $display("FAIL csl_idle_busy: got %b want 0", spiBUSY); end
    issue(spiopCSH, 8'h00); wait_done(n);
    checks++; if (n != 1) begin errors++; $display("FAIL csh_latency: got %0d want 1", n); end
    checks++; if (sdCS !== 1'b1) begin errors++; $display("FAIL csh_cs: got %b want 1", sdCS); end
    spiOP = spiopNOP; step(); step();
  endtask

  task automatic test_slow_byte();
    int n, base_r, base_d;
    cmd(spiopCSL);
    card_load(8'h3C);
    base_r = rise_cnt; base_d = done_cnt;
    issue(spiopTR, 8'hA5); spiOP = spiopNOP;
    wait_done(n);
    checks++; if (n != 2001) begin errors++; $display("FAIL slow_latency: got %0d want 2001", n); end
    checks++; if (spiRXD !== 8'h3C) begin errors++; $display("FAIL slow_rxd: got %h want 3c", spiRXD); end
    checks++; if (mosi_cap !== 8'hA5) begin errors++; $display("FAIL slow_mosi: got %h want a5", mosi_cap); end
    checks++; if (rise_cnt - base_r != 8) begin errors++; $display("FAIL slow_rises: got %0d want 8", rise_cnt - base_r); end
    for (int k = 1; k < 8; k++) begin
      time d;
      d = rise_t[(base_r + k) % 16] - rise_t[(base_r + k - 1) % 16];
      checks++; if (d != 2500) begin errors++; $display("FAIL slow_period%0d: got %0t want 2500", k, d); end
    end
    checks++; if (sdCS !== 1'b0) begin errors++; $display("FAIL slow_cs: got %b want 0", sdCS); end
    step(); step();
    checks++; if (done_cnt - base_d != 1) begin errors++; $display("FAIL slow_done_cnt: got %0d want 1", done_cnt - base_d); end
  endtask

  task automatic test_fast_ff();
    int n, base_m;
    cmd(spiopFAST);
    card_load(8'h00);
    base_m = mosi0_cnt;
    issue(spiopTR, 8'hFF); spiOP = spiopNOP;
    wait_done(n);
    checks++; if (n != 33) begin errors++; $display("FAIL fast_latency: got %0d want 33", n); end
    checks++; if (spiRXD !== 8'h00) begin errors++; $display("FAIL fast_rxd: got %h want 00", spiRXD); end
    checks++; if (mosi0_cnt - base_m != 0) begin errors++; $display("FAIL fast_mosi_low: got %0d want 0", mosi0_cnt - base_m); end
    step(); step();
  endtask

  task automatic test_op_switch();
    int n, base_d;
    card_load(8'hC3);
    base_d = done_cnt;
    issue(spiopTR, 8'h5A);
    repeat (10) step();
    spiOP = spiopCSH;
    wait_done(n);
    checks++; if (n + 10 != 33) begin errors++; $display("FAIL sw_latency: got %0d want 33", n + 10); end
    checks++; if (spiRXD !== 8'hC3) begin errors++; $display("FAIL sw_rxd: got %h want c3", spiRXD); end
    checks++; if (mosi_cap !== 8'h5A) begin errors++; $display("FAIL sw_mosi: got %h want 5a", mosi_cap); end
    repeat (5) step();
    checks++; if (sdCS !== 1'b0) begin errors++; $display("FAIL sw_cs_held: got %b want 0", sdCS); end
    checks++; if (done_cnt - base_d != 1) begin errors++; $display("FAIL sw_done_cnt: got %0d want 1", done_cnt - base_d); end
    spiOP = spiopNOP; step(); step();
    checks++; if (sdCS !== 1'b0) begin errors++; $display("FAIL sw_cs_nop: got %b want 0", sdCS); end
    issue(spiopCSH, 8'h00);
    checks++; if (sdCS !== 1'b1) begin errors++; $display("FAIL sw_cs_after: got %b want 1", sdCS); end
    spiOP = spiopNOP; step(); step();
  endtask

  task automatic test_reset_mid();
    int n, base_r, base_d;
    cmd(spiopFAST); cmd(spiopCSL);
    card_load(8'hFF);
    base_r = rise_cnt; base_d = done_cnt;
    issue(spiopTR, 8'h81); spiOP = spiopNOP;
    n = 0;
    while (rise_cnt - base_r < 3 && n < 200) begin step(); n++; end
    checks++; if (rise_cnt - base_r != 3) begin errors++; $display("FAIL rm_rises: got %0d want 3", rise_cnt - base_r); end
    #2 reset = 1'b0; #1;
    checks++; if (sdCS !== 1'b1)    begin errors++; $display("FAIL rm_cs: got %b want 1", sdCS); end
    checks++; if (sdSCLK !== 1'b0)  begin errors++; $display("FAIL rm_sclk: got %b want 0", sdSCLK); end
    checks++; if (sdMOSI !== 1'b1)  begin errors++; $display("FAIL rm_mosi: got %b want 1", sdMOSI); end
    checks++; if (spiBUSY !== 1'b0) begin errors++; $display("FAIL rm_busy: got %b want 0", spiBUSY); end
    step(); reset = 1'b1;
    repeat (40) step();
    checks++; if (done_cnt - base_d != 0) begin errors++; $display("FAIL rm_no_done: got %0d want 0", done_cnt - base_d); end
    checks++; if (spiRXD !== 8'h00) begin errors++; $display("FAIL rm_rxd: got %h want 00", spiRXD); end
  endtask

  task automatic test_clear();
    int n, base_d;
    cmd(spiopFAST); cmd(spiopCSL);
    card_load(8'hAA);
    issue(spiopTR, 8'h00); spiOP = spiopNOP;
    n = 0;
    while (sdSCLK !== 1'b1 && n < 200) begin step(); n++; end
    checks++; if (sdSCLK !== 1'b1) begin errors++; $display("FAIL clr_reach_high: got %b want 1", sdSCLK); end
    clear = 1'b1; step(); clear = 1'b0;
    checks++; if (sdCS !== 1'b1)    begin errors++; $display("FAIL clr_cs: got %b want 1", sdCS); end
    checks++; if (sdSCLK !== 1'b0)  begin errors++; $display("FAIL clr_sclk: got %b want 0", sdSCLK); end
    checks++; if (sdMOSI !== 1'b1)  begin errors++; $display("FAIL clr_mosi: got %b want 1", sdMOSI); end
    checks++; if (spiBUSY !== 1'b0) begin errors++; $display("FAIL clr_busy: got %b want 0", spiBUSY); end
    // Clear and a command on the same edge: the command is dropped
    base_d = done_cnt;
    spiOP = spiopCSL; clear = 1'b1; step(); clear = 1'b0; spiOP = spiopNOP;
    checks++; if (sdCS !== 1'b1) begin errors++; $display("FAIL clr_accept_cs: got %b want 1", sdCS); end
    step(); step();
    checks++; if (done_cnt - base_d != 0) begin errors++; $display("FAIL clr_accept_done: got %0d want 0", done_cnt - base_d); end
    // Mode fell back to slow
    cmd(spiopCSL);
    card_load(8'h00);
    issue(spiopTR, 8'h00); spiOP = spiopNOP;
    wait_done(n);
    checks++; if (n != 2001) begin errors++; $display("FAIL clr_slow_latency: got %0d want 2001", n); end
    step(); step();
  endtask

  initial begin
    test_reset();
    test_cs();
    test_slow_byte();
    test_fast_ff();
    test_op_switch();
    test_reset_mid();
    test_clear();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sd_spi_engine.md
Name: sd_spi_engine

Overview:
Byte-level SPI master between the SD sector sequencer (sd) and the physical SD card pins. The sequencer issues one command at a time (chip-select control, clock-speed select, or a full-duplex byte transfer) and receives a completion pulse plus the received byte. The block owns sdSCLK/sdMOSI/sdCS timing (SPI mode 0, MSB first), so the sequencer never handles bit timing.

Parameters:
SLOW_DIV, 125, clk cycles per SCLK half-period in slow (init) mode; gives ≤400 kHz at 100 MHz.
FAST_DIV, 2, clk cycles per SCLK half-period in fast (data) mode; minimum legal value 1.

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
clear  in  1  synchronous IOCLR, same effect as reset
spiOP  in  3  command (spiOP_t): spiopNOP, spiopCSL, spiopCSH, spiopFAST, spiopSLOW, spiopTR
spiTXD  in  [0:7]  byte to transmit, sampled on spiopTR accept; bit 0 is the MSB
spiRXD  out  [0:7]  received byte, valid from spiDONE until the next spiopTR accept
spiDONE  out  1  one-clk completion pulse
spiBUSY  out  1  high from accept until the handshake returns to IDLE
sdMISO  in  1  card data out
sdMOSI  out  1  card data in
sdSCLK  out  1  SPI clock
sdCS  out  1  chip select, active low

Behaviour:
- Reset (reset low, async) or clear high (sync): state=IDLE, sdCS=1, sdSCLK=0, sdMOSI=1, mode=slow, spiRXD=8'h00, spiDONE=0, spiBUSY=0, counters=0. This takes effect mid-transfer with no partial byte reported.
- States (sdspiSTATE_t): IDLE, LOW, HIGH, DONE, ACK.
- IDLE: a command is accepted on a clk edge where spiOP≠NOP. spiBUSY rises on the next cycle.
  - CSL sets sdCS=0. CSH sets sdCS=1. FAST selects FAST_DIV. SLOW selects SLOW_DIV.
  - Each of these goes straight to DONE, so spiDONE is asserted in the cycle after accept.
  - TR loads the shift register with spiTXD, drives sdMOSI=spiTXD[0], clears the bit count, loads the divider, and enters LOW.
- LOW: sdSCLK=0 for DIV cycles, then sdSCLK goes 1, sdMISO is shifted into the receive register LSB, and the state goes to HIGH.
- HIGH: sdSCLK=1 for DIV cycles, then sdSCLK goes 0 and the bit count increments.
  - Count <8: present the next TX bit on sdMOSI and return to LOW.
  - Count =8: sdMOSI=1, copy the receive register to spiRXD, go to DONE.
- TR latency: accept edge to spiDONE high is exactly 16*DIV+1 cycles. SCLK period is 2*DIV. MOSI is stable ≥DIV cycles before each rising edge.
- DONE: spiDONE=1 for exactly one cycle, then ACK.
- ACK: wait until spiOP==NOP, then go to IDLE and drop spiBUSY.
  - A held op therefore never re-executes.
  - Op changes while busy are ignored.
- DIV is the one latched at TR accept. FAST/SLOW are only accepted in IDLE, so speed never changes mid-byte.
- sdCS is never changed by TR. The sequencer issues CSL/CSH explicitly.
- Width rule: the divider counter is $clog2(SLOW_DIV+1) bits and counts DIV-1 down to 0.
- Simultaneous clear and accept: clear wins and the command is discarded.

Decomposition:
- Package sdspi_types (already imported by sd):
  - spiOP_t enum (NOP=0, CSL, CSH, FAST, SLOW, TR).
  - sdspiSTATE_t enum.
  - Default divider constants.
- Sub-module sd_spi_div: loadable down-counter, inputs load/div, output tick when it reaches zero. Used for both half-periods.
- The shift register and FSM stay in sd_spi_engine.

Test Plan:
- Reset low mid-byte (FAST_DIV=2, after 3 SCLK rises) → sdCS=1, sdSCLK=0, sdMOSI=1, spiBUSY=0 within the same cycle. No spiDONE.
- CSL then NOP → spiDONE one cycle after accept, sdCS=0. CSH → sdCS=1. spiDONE never repeats while spiOP is held.
- Slow mode, spiTXD=8'hA5, sdsim returning 8'h3C → 8 SCLK pulses each 250 clks long, MOSI bits 1,0,1,0,0,1,0,1 at rising edges, spiRXD=8'h3C, spiDONE exactly 2001 cycles after accept.
- FAST then TR spiTXD=8'hFF, MISO held 0 → byte takes 16*2+1=33 cycles, spiRXD=8'h00, sdMOSI=1 throughout.
- spiOP switched from TR to CSH mid-transfer → ignored. Byte completes, and CSH executes only after an intervening NOP; sdCS stays 0 until then.
- clear pulsed during HIGH in fast mode → same state as reset, mode returns to slow (next TR takes 2001 cycles).
